// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake,
// holds each instruction for the decoder and resolves the next PC on instr_done.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef PCSEL_PCPLUSFOUR
`define PCSEL_PCPLUSFOUR 2'b00
`endif
`ifndef PCSEL_PCOFFSET
`define PCSEL_PCOFFSET 2'b01
`endif
`ifndef PCSEL_REGOFFSET
`define PCSEL_REGOFFSET 2'b10
`endif

module fetch_unit #(
    parameter int                   WORD_SIZE = `WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter int                   TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [WORD_SIZE-1:0] imem_addr,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] pc_plus4,
    input  logic                 instr_done,
    input  logic [1:0]           pc_mux,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] imm,
    input  logic [WORD_SIZE-1:0] reg_base,
    output logic                 fetch_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_ERR
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] next_pc;
    logic [WORD_SIZE-1:0] seq_pc;
    logic [WORD_SIZE-1:0] imm_words;
    logic [CNT_W-1:0]     count;
    logic                 sel_legal;
    logic                 redirect_ok;
    logic                 load_pc;
    logic                 load_instr;

    assign seq_pc    = pc + WORD_SIZE'(4);
    assign imm_words = imm << 2;
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign pc_plus4  = seq_pc;

    // Next-PC resolution; an unknown select or a non-word target is an illegal redirect.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_pc   = seq_pc;
        sel_legal = 1'b1;
        case (pc_mux)
            `PCSEL_PCPLUSFOUR: next_pc = seq_pc;
            `PCSEL_PCOFFSET:   next_pc = branch_taken ? (seq_pc + imm_words) : seq_pc;
            `PCSEL_REGOFFSET:  next_pc = reg_base + imm_words;
            default:           sel_legal = 1'b0;
        endcase
        redirect_ok = sel_legal && (next_pc[1:0] == 2'b00);
    end

    always_comb begin
        state_n     = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        load_pc     = 1'b0;
        load_instr  = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_n = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // An ack on the last allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_n    = S_HOLD;
                end else if (count == CNT_W'(TIMEOUT - 1)) begin
                    state_n = S_ERR;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (instr_done) begin
                    if (redirect_ok) begin
                        load_pc = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                state_n = S_ERR;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            if (load_pc) begin
                pc <= next_pc;
            end
            if (load_instr) begin
                instr <= imem_rdata;
            end
            if (state == S_FETCH && !imem_ack) begin
                count <= count + CNT_W'(1);
            end else begin
                count <= '0;
            end
        end
    end

endmodule
